// File: rtl/hamming_scrub_ctrl.sv
// Memory scrubber: walks DEPTH Hamming(16,11) SECDED codewords, rewrites single-bit errors, logs double-bit errors.
// Latency: 2 cycles per clean or uncorrectable word, 3 per corrected word, plus one cycle per mem_ack wait cycle.
// Backpressure: mem_req/mem_we/mem_addr/mem_wdata are held until mem_ack; mem_ack is ignored while mem_req is low.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   start, clear           begin a pass (sampled in IDLE); zero the error log and counters
//   busy, done             FSM outside IDLE; one-cycle end-of-pass pulse
//   mem_req/we/addr/wdata  single-port memory request (we=1 is a write-back)
//   mem_ack, mem_rdata     request accepted; read data valid with the ack
//   sec_cnt, ded_cnt       saturating counts of corrected / uncorrectable words
//   ded_flag, ded_addr     sticky first double-error flag and its address
//
// Build option: define HAMMING_SCRUB_DED_HALT_EN to end the pass at the first double-bit error.
//
// Codeword layout: bit i holds Hamming position i (1..15), parity bits at positions 1,2,4,8,
// data at 3,5,6,7,9..15, and bit 0 is the overall parity over bits 15:1.

module hamming_decoder (
  input  logic [15:0] cw,
  output logic [15:0] fixed,
  output logic        sed,
  output logic        ded
);

  logic [3:0] syn;
  logic       par;

  always_comb begin
    syn = '0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) syn = syn ^ 4'(i);
    end
    par = ^cw;
    // Odd overall parity means one flipped bit (syndrome 0 points at bit 0 itself);
    // even parity with a non-zero syndrome means two flipped bits.
    sed   = par | (syn != 4'd0);
    ded   = ~par & (syn != 4'd0);
    fixed = cw;
    if (par) fixed[syn] = ~cw[syn];
  end

endmodule

module hamming_scrub_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic              ded_flag,
  output logic [ADDR_W-1:0] ded_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef HAMMING_SCRUB_DED_HALT_EN
  localparam logic HALT_ON_DED = 1'b1;
`else
  localparam logic HALT_ON_DED = 1'b0;
`endif

  state_t      state;
  logic [15:0] cw_q;
  logic [15:0] dec_fixed;
  logic        dec_sed;
  logic        dec_ded;
  logic        sec_hit;
  logic        ded_hit;
  logic        at_last;

  // mem_addr doubles as the scan address register.
  hamming_decoder u_dec (
    .cw    (cw_q),
    .fixed (dec_fixed),
    .sed   (dec_sed),
    .ded   (dec_ded)
  );

  assign sec_hit = (state == S_CHECK) & dec_sed & ~dec_ded;
  assign ded_hit = (state == S_CHECK) & dec_ded;
  assign at_last = (mem_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cw_q      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_READ;
            mem_addr <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_READ: begin
          if (mem_ack) begin
            cw_q    <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (sec_hit) begin
            mem_wdata <= dec_fixed;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            state     <= S_WRITE;
          end else if ((ded_hit && HALT_ON_DED) || at_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            state    <= S_READ;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (at_last) begin
              mem_req <= 1'b0;
              state   <= S_DONE;
              done    <= 1'b1;
            end else begin
              // Next read follows the write-back with mem_req held high.
              mem_addr <= mem_addr + ADDR_W'(1);
              state    <= S_READ;
            end
          end
        end
        S_DONE: begin
          mem_addr <= '0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Error log; clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt  <= '0;
      ded_cnt  <= '0;
      ded_flag <= 1'b0;
      ded_addr <= '0;
    end else if (clear) begin
      sec_cnt  <= '0;
      ded_cnt  <= '0;
      ded_flag <= 1'b0;
      ded_addr <= '0;
    end else begin
      if (sec_hit && (sec_cnt != '1)) sec_cnt <= sec_cnt + CNT_W'(1);
      if (ded_hit) begin
        if (ded_cnt != '1) ded_cnt <= ded_cnt + CNT_W'(1);
        if (!ded_flag) begin
          ded_flag <= 1'b1;
          ded_addr <= mem_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl with DEPTH=4, ADDR_W=2, CNT_W=2 and a responding memory model.
// The memory model acks after a programmable random delay and can withhold write acks.
// Request stability is tracked across every wait cycle.

module tb_hamming_scrub_ctrl;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              clear;
  logic              busy;
  logic              done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic [CNT_W-1:0]  sec_cnt;
  logic [CNT_W-1:0]  ded_cnt;
  logic              ded_flag;
  logic [ADDR_W-1:0] ded_addr;

  hamming_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .sec_cnt   (sec_cnt),
    .ded_cnt   (ded_cnt),
    .ded_flag  (ded_flag),
    .ded_addr  (ded_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Explicit parity equations for the codeword layout (positions 1..15, overall parity in bit 0).
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    c        = '0;
    c[3]     = d[0];
    c[5]     = d[1];
    c[6]     = d[2];
    c[7]     = d[3];
    c[15:9]  = d[10:4];
    c[1]     = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2]     = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4]     = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8]     = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[0]     = ^c[15:1];
    return c;
  endfunction

  logic [15:0] mem  [DEPTH];
  logic [15:0] gold [DEPTH];

  // Memory model state.
  int          max_dly     = 0;
  bit          spur_ack    = 1'b0;
  bit          hold_writes = 1'b0;
  int          wr_cnt      = 0;
  int          wr_addr     = 0;
  logic [15:0] wr_data     = '0;
  int          waits       = 0;
  int          stab_err    = 0;

  initial begin
    int          wl;
    bit          in_req;
    bit          prev_ack;
    logic [18:0] snap;
    wl        = 0;
    in_req    = 1'b0;
    prev_ack  = 1'b0;
    snap      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!in_req || prev_ack) begin
          in_req = 1'b1;
          wl     = $urandom_range(0, max_dly);
          snap   = {mem_we, mem_addr, mem_wdata};
        end else if ({mem_we, mem_addr, mem_wdata} !== snap) begin
          stab_err++;
        end
        if (hold_writes && mem_we) begin
          mem_ack = 1'b0;
        end else if (wl == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            wr_addr = int'(mem_addr);
            wr_data = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
          end
        end else begin
          mem_ack = 1'b0;
          wl--;
          waits++;
        end
      end else begin
        in_req  = 1'b0;
        mem_ack = spur_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      prev_ack = mem_ack;
    end
  end

  task automatic load_gold();
    for (int i = 0; i < DEPTH; i++) mem[i] = gold[i];
  endtask

  function automatic int mem_bad();
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== gold[i]) bad++;
    return bad;
  endfunction

  task automatic reset_log();
    wr_cnt   = 0;
    wr_addr  = 0;
    wr_data  = '0;
    waits    = 0;
    stab_err = 0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Returns at the negedge inside the first READ cycle.
  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n counts cycles from the first READ cycle (n=0) to the cycle where done is high.
  task automatic wait_done(input int clear_at, output int n);
    n     = 0;
    clear = (clear_at == 0);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      clear = (n == clear_at);
    end
    clear = 1'b0;
    if (n >= 300) chk("done_timeout", 32'(n), 32'd0);
  endtask

  int n;
  int expected_n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    gold[0] = enc(11'h18E);
    gold[1] = enc(11'h000);
    gold[2] = enc(11'h7FF);
    gold[3] = enc(11'h2A5);
    load_gold();

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cnts", {16'(sec_cnt), 16'(ded_cnt)}, 32'd0);
    chk("rst_ded", {31'(ded_addr), ded_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean pass, zero-wait ack
    reset_log();
    start_pass();
    chk("clean_first_read", {29'(mem_addr), mem_we, mem_req, busy}, 32'b011);
    wait_done(-1, n);
    chk("clean_done_cycle", 32'(n), 32'd8);
    chk("clean_busy_in_done", 32'(busy), 32'd1);
    chk("clean_sec", 32'(sec_cnt), 32'd0);
    chk("clean_ded", 32'(ded_cnt), 32'd0);
    chk("clean_writes", 32'(wr_cnt), 32'd0);
    @(negedge clk);
    chk("clean_done_pulse", {30'(0), done, busy}, 32'd0);

    // Single-bit error: bit 2 of word 1
    reset_log();
    mem[1] = gold[1] ^ 16'h0004;
    start_pass();
    wait_done(-1, n);
    chk("sec_done_cycle", 32'(n), 32'd9);
    chk("sec_writes", 32'(wr_cnt), 32'd1);
    chk("sec_wr_addr", 32'(wr_addr), 32'd1);
    chk("sec_wr_data", 32'(wr_data), 32'(gold[1]));
    chk("sec_cnt", 32'(sec_cnt), 32'd1);
    chk("sec_mem_clean", 32'(mem_bad()), 32'd0);

    // Double-bit error: bits 2 and 3 of word 2
    pulse_clear();
    chk("clear_sec", 32'(sec_cnt), 32'd0);
    reset_log();
    mem[2] = gold[2] ^ 16'h000C;
    start_pass();
    wait_done(-1, n);
`ifdef HAMMING_SCRUB_DED_HALT_EN
    expected_n = 6;
`else
    expected_n = 8;
`endif
    chk("ded_done_cycle", 32'(n), 32'(expected_n));
    chk("ded_writes", 32'(wr_cnt), 32'd0);
    chk("ded_cnt", 32'(ded_cnt), 32'd1);
    chk("ded_flag", 32'(ded_flag), 32'd1);
    chk("ded_addr", 32'(ded_addr), 32'd2);
    chk("ded_sec", 32'(sec_cnt), 32'd0);
    chk("ded_mem_kept", 32'(mem[2]), 32'(gold[2] ^ 16'h000C));
    @(negedge clk);
    chk("ded_addr_return", 32'(mem_addr), 32'd0);
    mem[2] = gold[2];
    pulse_clear();
    chk("clear_ded", {16'(ded_cnt), 15'(ded_addr), ded_flag}, 32'd0);

    // Random ack delays, spurious acks while idle, single-bit error on word 1
    reset_log();
    max_dly  = 3;
    spur_ack = 1'b1;
    mem[1]   = gold[1] ^ 16'h0004;
    start_pass();
    wait_done(-1, n);
    chk("dly_done_cycle", 32'(n), 32'(9 + waits));
    chk("dly_stable", 32'(stab_err), 32'd0);
    chk("dly_writes", 32'(wr_cnt), 32'd1);
    chk("dly_wr_addr", 32'(wr_addr), 32'd1);
    chk("dly_wr_data", 32'(wr_data), 32'(gold[1]));
    chk("dly_sec", 32'(sec_cnt), 32'd1);
    chk("dly_mem_clean", 32'(mem_bad()), 32'd0);
    max_dly  = 0;
    spur_ack = 1'b0;
    pulse_clear();

    // Reset asserted while the write-back waits for its ack
    reset_log();
    hold_writes = 1'b1;
    mem[1]      = gold[1] ^ 16'h0004;
    start_pass();
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstw_reached_write", 32'(mem_we), 32'd1);
    chk("rstw_sec_before", 32'(sec_cnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_ctl", {29'(0), mem_req, busy, done}, 32'd0);
    chk("rstw_we_addr", {29'(0), mem_we, 2'(mem_addr)}, 32'd0);
    chk("rstw_wdata", 32'(mem_wdata), 32'd0);
    chk("rstw_log", {15'(sec_cnt), 15'(ded_cnt), ded_flag, 1'b0}, 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    hold_writes = 1'b0;
    reset_log();
    start_pass();
    chk("rstw_rescan_addr", {29'(mem_addr), mem_we, mem_req, busy}, 32'b011);
    wait_done(-1, n);
    chk("rstw_done_cycle", 32'(n), 32'd9);
    chk("rstw_sec", 32'(sec_cnt), 32'd1);
    chk("rstw_mem_clean", 32'(mem_bad()), 32'd0);
    pulse_clear();

    // clear in the CHECK cycle of the corrected word (cycle 3) beats the increment
    reset_log();
    mem[1] = gold[1] ^ 16'h0004;
    start_pass();
    wait_done(3, n);
    chk("clr_done_cycle", 32'(n), 32'd9);
    chk("clr_sec", 32'(sec_cnt), 32'd0);
    chk("clr_writes", 32'(wr_cnt), 32'd1);

    // Four corrected words into a 2-bit counter
    reset_log();
    for (int i = 0; i < DEPTH; i++) mem[i] = gold[i] ^ 16'h0020;
    start_pass();
    wait_done(-1, n);
    chk("sat_done_cycle", 32'(n), 32'd12);
    chk("sat_writes", 32'(wr_cnt), 32'd4);
    chk("sat_sec", 32'(sec_cnt), 32'd3);
    chk("sat_mem_clean", 32'(mem_bad()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
